// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants for the branch resolution sequencer: field widths, opcodes, FSM encoding.
package branch_resolve_ctrl_pkg;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned IMM_W = 16;
    localparam int unsigned ST_W  = 2;

    localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE  = 6'b000101;
    localparam logic [OPC_W-1:0] OP_BGEZ = 6'b000001;
    localparam logic [OPC_W-1:0] OP_BGT  = 6'b000111;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_EVAL = 2'd2;
    localparam logic [ST_W-1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Decode/fetch-facing signal bundle of the branch resolution sequencer.
interface branch_resolve_ctrl_if
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              br_valid_i;
    logic              br_ready_o;
    logic [OPC_W-1:0]  br_opcode_i;
    logic [DATA_W-1:0] br_pc4_i;
    logic [IMM_W-1:0]  br_imm_i;
    logic [1:0]        opnd_rdy_i;
    logic [DATA_W-1:0] opnd1_i;
    logic [DATA_W-1:0] opnd2_i;
    logic              kill_i;
    logic              stall_o;
    logic              resp_valid_o;
    logic              taken_o;
    logic              flush_o;
    logic [DATA_W-1:0] redirect_pc_o;
    logic [CNT_W-1:0]  br_cnt_o;
    logic [CNT_W-1:0]  taken_cnt_o;

    modport master (
        output br_valid_i, br_opcode_i, br_pc4_i, br_imm_i, opnd_rdy_i, opnd1_i, opnd2_i, kill_i,
        input  br_ready_o, stall_o, resp_valid_o, taken_o, flush_o, redirect_pc_o, br_cnt_o, taken_cnt_o
    );

    modport slave (
        input  br_valid_i, br_opcode_i, br_pc4_i, br_imm_i, opnd_rdy_i, opnd1_i, opnd2_i, kill_i,
        output br_ready_o, stall_o, resp_valid_o, taken_o, flush_o, redirect_pc_o, br_cnt_o, taken_cnt_o
    );
endinterface

// File: rtl/branch_resolve_ctrl_cmp.sv
// Combinational signed branch-condition comparator.
module branch_cmp
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [OPC_W-1:0]  i_opcode,
    input  logic [DATA_W-1:0] i_src1,
    input  logic [DATA_W-1:0] i_src2,
    output logic              o_taken_c
);

    // Evaluate the branch condition; unknown opcodes resolve as not taken.
    always_comb begin
        o_taken_c = 1'b0;
        case (i_opcode)
            OP_BEQ:  o_taken_c = (i_src1 == i_src2);
            OP_BNE:  o_taken_c = (i_src1 != i_src2);
            OP_BGEZ: o_taken_c = ($signed(i_src1) >= $signed(i_src2));
            OP_BGT:  o_taken_c = ($signed(i_src1) >  $signed(i_src2));
            default: o_taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: waits for operands, evaluates once, strobes redirect/flush to fetch.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    branch_resolve_ctrl_if.slave bus
);

    logic [ST_W-1:0]   r_state,    w_state_nx;
    logic [OPC_W-1:0]  r_opcode,   w_opcode_nx;
    logic [DATA_W-1:0] r_pc4,      w_pc4_nx;
    logic [IMM_W-1:0]  r_imm,      w_imm_nx;
    logic [DATA_W-1:0] r_opnd1,    w_opnd1_nx;
    logic [DATA_W-1:0] r_opnd2,    w_opnd2_nx;
    logic              r_v1,       w_v1_nx;
    logic              r_v2,       w_v2_nx;
    logic              r_taken,    w_taken_nx;
    logic [DATA_W-1:0] r_redirect, w_redirect_nx;
    logic [CNT_W-1:0]  r_br_cnt,   w_br_cnt_nx;
    logic [CNT_W-1:0]  r_tk_cnt,   w_tk_cnt_nx;
    logic              r_resp,     w_resp_nx;
    logic              r_flush,    w_flush_nx;
    logic              r_ready,    w_ready_nx;
    logic              r_stall,    w_stall_nx;

    logic              w_eval;
    logic [OPC_W-1:0]  w_cmp_op;
    logic [DATA_W-1:0] w_cmp_a;
    logic [DATA_W-1:0] w_cmp_b;
    logic              w_cmp_taken;
    logic [DATA_W-1:0] w_imm_sx;
    logic [DATA_W-1:0] w_target;
    logic [CNT_W-1:0]  w_br_cnt_inc;
    logic [CNT_W-1:0]  w_tk_cnt_inc;

    // Comparator sees the captured branch only while evaluating; otherwise parked at zero.
    assign w_eval   = (r_state == ST_EVAL);
    assign w_cmp_op = w_eval ? r_opcode : '0;
    assign w_cmp_a  = w_eval ? r_opnd1  : '0;
    assign w_cmp_b  = w_eval ? r_opnd2  : '0;

    branch_cmp #(.DATA_W(DATA_W)) u_cmp (
        .i_opcode  (w_cmp_op),
        .i_src1    (w_cmp_a),
        .i_src2    (w_cmp_b),
        .o_taken_c (w_cmp_taken)
    );

    // Word-offset target, wraps modulo 2^DATA_W.
    assign w_imm_sx = DATA_W'($signed(r_imm));
    assign w_target = r_pc4 + (w_imm_sx << 2);

    // Saturating statistics increments.
    assign w_br_cnt_inc = (r_br_cnt == '1) ? r_br_cnt : r_br_cnt + CNT_W'(1);
    assign w_tk_cnt_inc = (r_tk_cnt == '1) ? r_tk_cnt : r_tk_cnt + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx    = r_state;
        w_opcode_nx   = r_opcode;
        w_pc4_nx      = r_pc4;
        w_imm_nx      = r_imm;
        w_opnd1_nx    = r_opnd1;
        w_opnd2_nx    = r_opnd2;
        w_v1_nx       = r_v1;
        w_v2_nx       = r_v2;
        w_taken_nx    = r_taken;
        w_redirect_nx = r_redirect;
        w_br_cnt_nx   = r_br_cnt;
        w_tk_cnt_nx   = r_tk_cnt;
        w_resp_nx     = 1'b0;
        w_flush_nx    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.br_valid_i && !bus.kill_i) begin
                    w_opcode_nx = bus.br_opcode_i;
                    w_pc4_nx    = bus.br_pc4_i;
                    w_imm_nx    = bus.br_imm_i;
                    if (bus.opnd_rdy_i[0]) w_opnd1_nx = bus.opnd1_i;
                    if (bus.opnd_rdy_i[1]) w_opnd2_nx = bus.opnd2_i;
                    w_v1_nx     = bus.opnd_rdy_i[0];
                    w_v2_nx     = bus.opnd_rdy_i[1];
                    w_state_nx  = (&bus.opnd_rdy_i) ? ST_EVAL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.kill_i) begin
                    w_v1_nx    = 1'b0;
                    w_v2_nx    = 1'b0;
                    w_state_nx = ST_IDLE;
                end else begin
                    if (!r_v1 && bus.opnd_rdy_i[0]) begin
                        w_opnd1_nx = bus.opnd1_i;
                        w_v1_nx    = 1'b1;
                    end
                    if (!r_v2 && bus.opnd_rdy_i[1]) begin
                        w_opnd2_nx = bus.opnd2_i;
                        w_v2_nx    = 1'b1;
                    end
                    if (w_v1_nx && w_v2_nx) w_state_nx = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (bus.kill_i) begin
                    w_v1_nx    = 1'b0;
                    w_v2_nx    = 1'b0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_taken_nx    = w_cmp_taken;
                    w_redirect_nx = w_cmp_taken ? w_target : r_pc4;
                    w_br_cnt_nx   = w_br_cnt_inc;
                    if (w_cmp_taken) w_tk_cnt_nx = w_tk_cnt_inc;
                    w_resp_nx     = 1'b1;
                    w_flush_nx    = w_cmp_taken;
                    w_state_nx    = ST_RESP;
                end
            end
            ST_RESP: begin
                w_v1_nx    = 1'b0;
                w_v2_nx    = 1'b0;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        w_ready_nx = (w_state_nx == ST_IDLE);
        w_stall_nx = (w_state_nx == ST_WAIT) || (w_state_nx == ST_EVAL);
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_opcode   <= '0;
            r_pc4      <= '0;
            r_imm      <= '0;
            r_opnd1    <= '0;
            r_opnd2    <= '0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_taken    <= 1'b0;
            r_redirect <= '0;
            r_br_cnt   <= '0;
            r_tk_cnt   <= '0;
            r_resp     <= 1'b0;
            r_flush    <= 1'b0;
            r_ready    <= 1'b1;
            r_stall    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_opcode   <= w_opcode_nx;
            r_pc4      <= w_pc4_nx;
            r_imm      <= w_imm_nx;
            r_opnd1    <= w_opnd1_nx;
            r_opnd2    <= w_opnd2_nx;
            r_v1       <= w_v1_nx;
            r_v2       <= w_v2_nx;
            r_taken    <= w_taken_nx;
            r_redirect <= w_redirect_nx;
            r_br_cnt   <= w_br_cnt_nx;
            r_tk_cnt   <= w_tk_cnt_nx;
            r_resp     <= w_resp_nx;
            r_flush    <= w_flush_nx;
            r_ready    <= w_ready_nx;
            r_stall    <= w_stall_nx;
        end
    end

    assign bus.br_ready_o    = r_ready;
    assign bus.stall_o       = r_stall;
    assign bus.resp_valid_o  = r_resp;
    assign bus.taken_o       = r_taken;
    assign bus.flush_o       = r_flush;
    assign bus.redirect_pc_o = r_redirect;
    assign bus.br_cnt_o      = r_br_cnt;
    assign bus.taken_cnt_o   = r_tk_cnt;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized self-checking bench for branch_resolve_ctrl against a transaction-level model.
module tb_branch_resolve_ctrl;
    import branch_resolve_ctrl_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;

    branch_resolve_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bif ();

    branch_resolve_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: held outputs and saturating statistics.
    int          m_br  = 0;
    int          m_tk  = 0;
    logic        m_taken = 1'b0;
    logic [DW-1:0] m_redir = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [5:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            6'd4:    return sa == sb;
            6'd5:    return sa != sb;
            6'd1:    return sa >= sb;
            6'd7:    return sa >  sb;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs();
        bif.br_valid_i  = 1'b0;
        bif.kill_i      = 1'b0;
        bif.opnd_rdy_i  = 2'b00;
        bif.br_opcode_i = '0;
        bif.br_pc4_i    = '0;
        bif.br_imm_i    = '0;
        bif.opnd1_i     = '0;
        bif.opnd2_i     = '0;
        rst_n           = 1'b1;
    endtask

    task automatic chk_quiet(input string tag, input logic ready, input logic stall);
        chk({tag, "_ready"}, 64'(bif.br_ready_o), 64'(ready));
        chk({tag, "_stall"}, 64'(bif.stall_o), 64'(stall));
        chk({tag, "_resp"},  64'(bif.resp_valid_o), 64'(0));
        chk({tag, "_flush"}, 64'(bif.flush_o), 64'(0));
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_taken"}, 64'(bif.taken_o), 64'(m_taken));
        chk({tag, "_redir"}, 64'(bif.redirect_pc_o), 64'(m_redir));
        chk({tag, "_brcnt"}, 64'(bif.br_cnt_o), 64'(m_br));
        chk({tag, "_tkcnt"}, 64'(bif.taken_cnt_o), 64'(m_tk));
    endtask

    // One branch offered at cycle 0; operand k becomes ready at cycle dk and stays ready
    // (with changing values). kill_e >= 1 asserts kill_i for that cycle; rst_eval pulls reset in EVAL.
    // Caller must be at a negedge.
    task automatic run_branch(input logic [5:0] op, input logic [DW-1:0] pc4, input logic [15:0] imm,
                              input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input int d1, input int d2, input int kill_e, input bit rst_eval);
        int t;
        logic tk;
        t = (d1 > d2) ? d1 : d2;
        for (int c = 0; c <= t + 2; c++) begin
            bif.br_valid_i = (c == 0);
            if (c == 0) begin
                bif.br_opcode_i = op;
                bif.br_pc4_i    = pc4;
                bif.br_imm_i    = imm;
            end else begin
                bif.br_opcode_i = 6'($urandom);
                bif.br_pc4_i    = DW'($urandom);
                bif.br_imm_i    = 16'($urandom);
            end
            bif.opnd1_i    = (c == d1) ? a : DW'($urandom);
            bif.opnd2_i    = (c == d2) ? b : DW'($urandom);
            bif.opnd_rdy_i = {(c >= d2), (c >= d1)};
            bif.kill_i     = (c == kill_e);
            rst_n          = !(rst_eval && (c == t + 1));
            @(negedge clk);
            if (rst_eval && (c == t + 1)) begin
                m_br = 0; m_tk = 0; m_taken = 1'b0; m_redir = '0;
                chk_quiet("rst_eval", 1'b1, 1'b0);
                chk_held("rst_eval");
                break;
            end else if ((c == kill_e) && (c >= 1) && (c <= t + 1)) begin
                chk_quiet("kill", 1'b1, 1'b0);
                chk_held("kill");
                break;
            end else if (c <= t) begin
                chk_quiet("busy", 1'b0, 1'b1);
            end else if (c == t + 1) begin
                tk = ref_taken(op, a, b);
                m_taken = tk;
                m_redir = tk ? (pc4 + DW'(int'($signed(imm)) * 4)) : pc4;
                if (m_br < CNT_MAX) m_br++;
                if (tk && (m_tk < CNT_MAX)) m_tk++;
                chk("resp_valid", 64'(bif.resp_valid_o), 64'(1));
                chk("resp_flush", 64'(bif.flush_o), 64'(tk));
                chk("resp_ready", 64'(bif.br_ready_o), 64'(0));
                chk("resp_stall", 64'(bif.stall_o), 64'(0));
                chk_held("resp");
            end else begin
                chk_quiet("after", 1'b1, 1'b0);
                chk_held("after");
            end
        end
        idle_inputs();
    endtask

    // Watchdog on the whole run.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            d1;
        int            d2;
        int            t;
        int            ke;

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_quiet("reset", 1'b1, 1'b0);
        chk_held("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // beq taken, forward target
        run_branch(OP_BEQ, 32'h0000_0104, 16'h0003, 32'd5, 32'd5, 0, 0, -1, 1'b0);
        chk("beq_redir_const", 64'(bif.redirect_pc_o), 64'h110);
        chk("beq_taken_const", 64'(bif.taken_o), 64'(1));

        // bgt -1 > 0 is false in signed compare
        run_branch(OP_BGT, 32'h0000_0200, 16'hFFFE, 32'hFFFF_FFFF, 32'd0, 0, 0, -1, 1'b0);
        chk("bgt_redir_const", 64'(bif.redirect_pc_o), 64'h200);

        // bne taken, backward target
        run_branch(OP_BNE, 32'h0000_0010, 16'hFFFE, 32'hFFFF_FFFF, 32'd0, 0, 0, -1, 1'b0);
        chk("bne_redir_const", 64'(bif.redirect_pc_o), 64'h8);

        // staggered operands, src2 late
        run_branch(OP_BGEZ, 32'h0000_1000, 16'h0010, 32'd7, 32'd7, 0, 3, -1, 1'b0);

        // kill in WAIT
        run_branch(OP_BEQ, 32'h0000_2000, 16'h0001, 32'd1, 32'd1, 0, 3, 2, 1'b0);

        // kill with br_valid in IDLE: not accepted
        bif.br_valid_i  = 1'b1;
        bif.kill_i      = 1'b1;
        bif.opnd_rdy_i  = 2'b11;
        bif.br_opcode_i = OP_BEQ;
        @(negedge clk);
        chk_quiet("idle_kill", 1'b1, 1'b0);
        idle_inputs();
        @(negedge clk);
        chk_quiet("idle_kill2", 1'b1, 1'b0);
        chk_held("idle_kill2");

        // kill in RESP is ignored
        run_branch(OP_BNE, 32'h0000_3000, 16'h0004, 32'd1, 32'd2, 0, 0, 2, 1'b0);

        // reset while in EVAL
        run_branch(OP_BEQ, 32'h0000_4000, 16'h0004, 32'd3, 32'd3, 1, 0, -1, 1'b1);

        // randomized branches
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: op = OP_BEQ;
                1: op = OP_BNE;
                2: op = OP_BGEZ;
                3: op = OP_BGT;
                4: op = 6'h23;
                default: op = 6'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                a = DW'($urandom_range(0, 4)) - DW'(2);
                b = DW'($urandom_range(0, 4)) - DW'(2);
            end else begin
                a = DW'($urandom);
                b = DW'($urandom);
            end
            d1 = $urandom_range(0, 3);
            d2 = $urandom_range(0, 3);
            t  = (d1 > d2) ? d1 : d2;
            ke = ($urandom_range(0, 5) == 0) ? $urandom_range(1, t + 2) : -1;
            run_branch(op, DW'($urandom), 16'($urandom), a, b, d1, d2, ke, 1'b0);
        end

        // saturation: enough taken branches to pin both counters
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            run_branch(OP_BEQ, DW'($urandom), 16'($urandom), 32'd9, 32'd9, 0, 0, -1, 1'b0);
        end
        chk("sat_brcnt", 64'(bif.br_cnt_o), 64'(CNT_MAX));
        chk("sat_tkcnt", 64'(bif.taken_cnt_o), 64'(CNT_MAX));

        // unknown opcode: not taken, counter stays saturated
        run_branch(6'h23, 32'h0000_5000, 16'h0001, 32'd4, 32'd4, 0, 0, -1, 1'b0);
        chk("op23_taken", 64'(bif.taken_o), 64'(0));
        chk("op23_brcnt", 64'(bif.br_cnt_o), 64'(CNT_MAX));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequencer for the pipeline's branch comparator in the ID/EX boundary of the MIPS-style CPU. It accepts one conditional branch at a time from decode and holds decode stalled until both source operands are available from the register file or forwarding. It then evaluates the condition through a single comparator instance and issues a one-cycle redirect/flush response to fetch. It also keeps saturating branch statistics for the performance counters.

Parameters:
DATA_W, 32, operand and PC width
CNT_W, 16, width of statistics counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-low reset
br_valid_i  in  1  decode presents a branch
br_ready_o  out  1  controller can accept a branch
br_opcode_i  in  6  instruction opcode field
br_pc4_i  in  DATA_W  PC+4 of the branch
br_imm_i  in  16  signed word offset
opnd_rdy_i  in  2  bit0/bit1: src1/src2 value valid this cycle
opnd1_i  in  DATA_W  src1 value, signed
opnd2_i  in  DATA_W  src2 value, signed
kill_i  in  1  abort from a later stage (exception or older flush)
stall_o  out  1  hold IF/ID
resp_valid_o  out  1  one-cycle resolution strobe
taken_o  out  1  branch taken, valid with resp_valid_o
flush_o  out  1  flush IF/ID, equals resp_valid_o & taken_o
redirect_pc_o  out  DATA_W  next PC, valid with resp_valid_o
br_cnt_o  out  CNT_W  branches resolved
taken_cnt_o  out  CNT_W  branches taken

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low (clk_i, rst_i). With rst_i=0 at a rising edge, all registers clear.
- Reset values: state IDLE; all outputs 0 except br_ready_o=1; counters 0; captured operands, operand-valid bits and target cleared.
- States: IDLE, WAIT, EVAL, RESP. br_ready_o=1 only in IDLE. stall_o=1 in WAIT and EVAL.
- IDLE, on br_valid_i & !kill_i:
  - Capture opcode, pc4 and imm.
  - Capture each operand whose opnd_rdy_i bit is 1, and set its valid bit.
  - If both bits are 1, go to EVAL; otherwise go to WAIT.
- WAIT: each cycle, capture any not-yet-valid operand whose rdy bit is 1. An already-captured operand is never overwritten. When both are valid, go to EVAL.
- EVAL: drive the captured operands and opcode into the comparator.
  - target = pc4 + (sign_ext(imm) << 2), computed modulo 2^DATA_W, with no overflow detection.
  - Register taken and redirect_pc (target if taken, else pc4).
  - Go to RESP.
- RESP:
  - resp_valid_o=1, flush_o=taken_o.
  - br_cnt_o +1; taken_cnt_o +1 if taken. Both saturate at all-ones.
  - Return to IDLE; no new accept in RESP.
  - Latency: accept at edge N with both operands ready gives EVAL in cycle N+1 and the response strobe in cycle N+2.
- Conditions, signed DATA_W compare:
  - 000100 beq: src1==src2
  - 000101 bne: src1!=src2
  - 000001 bgez-class: src1>=src2
  - 000111 bgt: src1>src2
  - any other opcode: not taken, but still counted in br_cnt_o.
- kill_i:
  - In WAIT or EVAL: next state IDLE, no response, counters unchanged, valid bits cleared.
  - In RESP: ignored; the response completes.
  - In IDLE simultaneous with br_valid_i: branch is not accepted.
- Reset mid-operation: in-flight branch dropped, no response. Reset takes priority over kill_i and br_valid_i.
- Outputs other than the strobes hold their last value between responses. Strobes are 0 outside RESP.

Decomposition:
- Shared package: opcode constants OP_BEQ, OP_BNE, OP_BGEZ, OP_BGT and the state encoding constants.
- Sub-module: branch_cmp, the combinational signed comparator taking opcode/src1/src2 and returning result. It is instantiated once and driven only in EVAL.

Test Plan:
- Basic taken branch: beq, pc4=0x00000104, imm=0x0003, opnd1=opnd2=5, rdy=11 → resp_valid_o=1 two cycles after accept, taken_o=1, flush_o=1, redirect_pc_o=0x00000110, br_cnt_o=1, taken_cnt_o=1.
- Signed compare and backward target: bgt, opnd1=0xFFFFFFFF (-1), opnd2=0, imm=0xFFFE → taken_o=0, redirect_pc_o=pc4, flush_o=0.
  - Same with bne and imm=0xFFFE, pc4=0x00000010 → taken_o=1, redirect_pc_o=0x00000008.
- Staggered operands: accept with rdy=01, src2 ready three cycles later, opnd1_i changed meanwhile:
  - stall_o=1 throughout WAIT.
  - The first-captured src1 value is used.
  - Response arrives 2 cycles after src2 ready.
- Abort: kill_i in WAIT → IDLE next cycle, no resp_valid_o, counters unchanged.
  - kill_i and br_valid_i together in IDLE → not accepted.
  - kill_i in RESP → response still issued.
- Reset and saturation: rst_i=0 in EVAL → no response, all outputs at reset values.
  - Preload by running 65535 taken branches (CNT_W=16), then one more → both counters stay 0xFFFF.
  - Opcode 0x23 → taken_o=0 and br_cnt_o increments (unless saturated).
